// File: rtl/i2c_av_serial_bus_controller_if.sv
// Byte-request handshake and SCL/status signals between the auto-init sequencer and the I2C bit engine.
interface i2c_av_serial_bus_controller_if;
  logic       clear_ack;
  logic       transfer_data;
  logic       send_start_bit;
  logic       send_stop_bit;
  logic [7:0] data_in;
  logic       serial_clk;
  logic       ack;
  logic       transfer_complete;

  modport master (
    input  clear_ack, transfer_data, send_start_bit, send_stop_bit, data_in,
    output serial_clk, ack, transfer_complete
  );

  modport slave (
    output clear_ack, transfer_data, send_start_bit, send_stop_bit, data_in,
    input  serial_clk, ack, transfer_complete
  );
endinterface

// File: rtl/i2c_av_serial_bus_controller.sv
// Bit-level I2C master: turns start/byte/stop requests into open-drain SCL/SDA waveforms
// and collects the slave acknowledge into a sticky NACK flag.
module i2c_av_serial_bus_controller #(
  parameter int unsigned QUARTER_CYCLES = 125
) (
  input  logic                                  clk,
  input  logic                                  reset,
  i2c_av_serial_bus_controller_if.master        bus,
  inout  wire                                   serial_data
);

  localparam int unsigned QW = $clog2(QUARTER_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BYTE,
    S_ACK,
    S_STOP,
    S_COMPLETE
  } state_e;

  state_e          state_q, state_d;
  logic [QW-1:0]   qcnt_q, qcnt_d;
  logic [1:0]      qtr_q, qtr_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            scl_q, scl_d;
  logic            sda_oe_q, sda_oe_d;
  logic            ack_q, ack_d;
  logic            tc_q, tc_d;
  logic            qend_c;
  logic            slot_end_c;

  assign qend_c     = (qcnt_q == QW'(QUARTER_CYCLES - 1));
  assign slot_end_c = qend_c && (qtr_q == 2'd3);

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      qcnt_q   <= '0;
      qtr_q    <= 2'd0;
      bit_q    <= 3'd7;
      shreg_q  <= 8'h00;
      scl_q    <= 1'b1;
      sda_oe_q <= 1'b0;
      ack_q    <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      qcnt_q   <= qcnt_d;
      qtr_q    <= qtr_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      scl_q    <= scl_d;
      sda_oe_q <= sda_oe_d;
      ack_q    <= ack_d;
      tc_q     <= tc_d;
    end
  end

  // Next state, quarter/bit timing and byte latch
  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    if (state_q != S_IDLE && state_q != S_COMPLETE) begin
      qcnt_d = qend_c ? '0 : qcnt_q + QW'(1);
      if (qend_c) qtr_d = qtr_q + 2'd1;
    end
    case (state_q)
      S_IDLE: begin
        qcnt_d = '0;
        qtr_d  = 2'd0;
        bit_d  = 3'd7;
        if (bus.transfer_data && bus.send_start_bit) begin
          state_d = S_START;
          shreg_d = bus.data_in;
        end else if (bus.send_stop_bit) begin
          state_d = S_STOP;
        end else if (bus.transfer_data) begin
          state_d = S_BYTE;
          shreg_d = bus.data_in;
        end
      end
      S_START: if (slot_end_c) state_d = S_BYTE;
      S_BYTE: begin
        if (slot_end_c) begin
          if (bit_q == 3'd0) state_d = S_ACK;
          else               bit_d   = bit_q - 3'd1;
        end
      end
      S_ACK:  if (slot_end_c) state_d = S_COMPLETE;
      S_STOP: if (slot_end_c) state_d = S_COMPLETE;
      S_COMPLETE: begin
        qcnt_d = '0;
        qtr_d  = 2'd0;
        if (!bus.transfer_data) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus levels and status derived from the upcoming state so they stay aligned with it
  always_comb begin
    scl_d    = 1'b1;
    sda_oe_d = 1'b0;
    tc_d     = (state_d == S_COMPLETE);
    ack_d    = ack_q;
    case (state_d)
      S_START: begin
        scl_d    = (qtr_d == 2'd1) || (qtr_d == 2'd2);
        sda_oe_d = qtr_d[1];
      end
      S_BYTE: begin
        scl_d    = qtr_d[1];
        sda_oe_d = !shreg_d[bit_d];
      end
      S_ACK:  scl_d = qtr_d[1];
      S_STOP: begin
        scl_d    = (qtr_d != 2'd0);
        sda_oe_d = !qtr_d[1];
      end
      S_COMPLETE: begin
        // Coming out of the ack slot the bus is parked with SCL and SDA low
        scl_d    = (state_q == S_ACK) ? 1'b0 : scl_q;
        sda_oe_d = (state_q == S_ACK) ? 1'b1 : sda_oe_q;
      end
      default: ;
    endcase
    if (state_d == S_START && state_q != S_START)
      ack_d = 1'b0;
    else if (state_q == S_ACK && qtr_q == 2'd2 && qend_c && serial_data)
      ack_d = 1'b1;
    else if (bus.clear_ack)
      ack_d = 1'b0;
  end

  assign serial_data           = sda_oe_q ? 1'b0 : 1'bz;
  assign bus.serial_clk        = scl_q;
  assign bus.ack               = ack_q;
  assign bus.transfer_complete = tc_q;

endmodule

// File: tb/tb_i2c_av_serial_bus_controller.sv
// Self-checking bench: a bus monitor decodes SCL/SDA into bits, START and STOP events and
// checks the bits against a scoreboard queue filled when each request is launched.
module tb_i2c_av_serial_bus_controller;
  localparam int unsigned Q = 4;

  logic clk = 1'b0;
  logic reset;
  logic slave_pull = 1'b0;
  logic slave_nack = 1'b0;
  wire  sda;

  pullup (sda);
  assign sda = slave_pull ? 1'b0 : 1'bz;

  i2c_av_serial_bus_controller_if bus ();

  i2c_av_serial_bus_controller #(.QUARTER_CYCLES(Q)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .serial_data (sda)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   start_cnt = 0;
  int   stop_cnt = 0;
  int   bit_idx;
  logic exp_q[$];
  logic exp_bit;
  logic prev_scl, prev_sda, prev_tc, pend, pend_v, cond;

  typedef struct {
    logic       start;
    logic       stop;
    logic       td;
    logic [7:0] data;
    logic       chg;
    logic       nack;
    int         lat;
    logic       exp_ack;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] d, input logic nack);
    logic [7:0] b;
    b = d;
    for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
    exp_q.push_back(nack);
  endtask

  // Bus monitor and acknowledging slave, sampled on the falling clock edge
  always @(negedge clk) begin
    if (reset) begin
      bit_idx    = 0;
      pend_v     = 1'b0;
      cond       = 1'b0;
      slave_pull = 1'b0;
      prev_scl   = 1'b1;
      prev_sda   = 1'b1;
      prev_tc    = 1'b0;
    end else begin
      if (bus.serial_clk && prev_scl && (sda !== prev_sda)) begin
        cond = 1'b1;
        if (sda === 1'b0) start_cnt++;
        else              stop_cnt++;
      end
      if (bus.serial_clk && !prev_scl) begin
        cond = 1'b0;
        if (!prev_tc) begin
          pend   = sda;
          pend_v = 1'b1;
        end
      end
      if (!bus.serial_clk && prev_scl) begin
        if (pend_v && !cond) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_bit got=%0b expected=none", pend);
          end else begin
            exp_bit = exp_q.pop_front();
            if (pend !== exp_bit) begin
              failures++;
              $display("FAIL sda_bit got=%0b expected=%0b", pend, exp_bit);
            end
          end
          bit_idx = (bit_idx == 8) ? 0 : bit_idx + 1;
          slave_pull = (bit_idx == 8) && !slave_nack;
        end
        pend_v = 1'b0;
      end
      prev_scl = bus.serial_clk;
      prev_sda = sda;
      prev_tc  = bus.transfer_complete;
    end
  end

  task automatic launch(input vec_t v);
    slave_nack = v.nack;
    if (v.td && !v.stop) push_byte(v.data, v.nack);
    @(posedge clk); #1;
    bus.transfer_data  = v.td;
    bus.send_start_bit = v.start;
    bus.send_stop_bit  = v.stop;
    bus.data_in        = v.data;
    @(posedge clk); #1;
    if (v.chg) bus.data_in = 8'h00;
  endtask

  task automatic wait_complete(output int n);
    n = 0;
    while (!bus.transfer_complete && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic drop_requests();
    bus.transfer_data  = 1'b0;
    bus.send_start_bit = 1'b0;
    bus.send_stop_bit  = 1'b0;
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int n, s0, p0;
    s0 = start_cnt;
    p0 = stop_cnt;
    launch(v);
    wait_complete(n);
    check({name, "_latency"}, 64'(n), 64'(v.lat));
    check({name, "_ack"}, 64'(bus.ack), 64'(v.exp_ack));
    drop_requests();
    @(posedge clk); #1;
    check({name, "_tc_low"}, 64'(bus.transfer_complete), 64'd0);
    check({name, "_idle_scl"}, 64'(bus.serial_clk), 64'd1);
    check({name, "_idle_sda"}, 64'(sda), 64'd1);
    check({name, "_bits_left"}, 64'(exp_q.size()), 64'd0);
    check({name, "_starts"}, 64'(start_cnt - s0), 64'(v.start && v.td));
    check({name, "_stops"}, 64'(stop_cnt - p0), 64'(v.stop));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    vec_t v;

    vecs[0] = '{start: 1'b1, stop: 1'b0, td: 1'b1, data: 8'h34, chg: 1'b0, nack: 1'b0, lat: 160, exp_ack: 1'b0};
    vecs[1] = '{start: 1'b1, stop: 1'b0, td: 1'b1, data: 8'h34, chg: 1'b0, nack: 1'b1, lat: 160, exp_ack: 1'b1};
    vecs[2] = '{start: 1'b0, stop: 1'b0, td: 1'b1, data: 8'hA5, chg: 1'b1, nack: 1'b0, lat: 144, exp_ack: 1'b1};
    vecs[3] = '{start: 1'b0, stop: 1'b1, td: 1'b0, data: 8'h00, chg: 1'b0, nack: 1'b0, lat: 16,  exp_ack: 1'b1};
    vecs[4] = '{start: 1'b1, stop: 1'b0, td: 1'b1, data: 8'hC3, chg: 1'b0, nack: 1'b0, lat: 160, exp_ack: 1'b0};
    vecs[5] = '{start: 1'b0, stop: 1'b1, td: 1'b1, data: 8'h77, chg: 1'b0, nack: 1'b0, lat: 16,  exp_ack: 1'b0};

    reset = 1'b1;
    bus.clear_ack = 1'b0;
    drop_requests();
    bus.data_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_scl", 64'(bus.serial_clk), 64'd1);
    check("rst_sda", 64'(sda), 64'd1);
    check("rst_ack", 64'(bus.ack), 64'd0);
    check("rst_tc", 64'(bus.transfer_complete), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // NACK sets the sticky flag; clear_ack in idle drops it
    run_vec("nack_again", vecs[1]);
    @(posedge clk); #1;
    check("ack_sticky_idle", 64'(bus.ack), 64'd1);
    bus.clear_ack = 1'b1;
    @(posedge clk); #1;
    bus.clear_ack = 1'b0;
    check("clear_ack", 64'(bus.ack), 64'd0);

    // transfer_data held past completion keeps COMPLETE without a new transfer
    v = '{start: 1'b0, stop: 1'b0, td: 1'b1, data: 8'h0F, chg: 1'b0, nack: 1'b0, lat: 144, exp_ack: 1'b0};
    launch(v);
    wait_complete(n);
    check("hold_latency", 64'(n), 64'd144);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("hold_tc%0d", k), 64'(bus.transfer_complete), 64'd1);
      check($sformatf("hold_scl%0d", k), 64'(bus.serial_clk), 64'd0);
    end
    drop_requests();
    @(posedge clk); #1;
    check("hold_release_tc", 64'(bus.transfer_complete), 64'd0);
    check("hold_release_scl", 64'(bus.serial_clk), 64'd1);
    check("hold_bits_left", 64'(exp_q.size()), 64'd0);

    // Reset during bit 3 of a byte aborts to idle levels
    run_vec("pre_reset_nack", vecs[1]);
    v = '{start: 1'b0, stop: 1'b0, td: 1'b1, data: 8'hFF, chg: 1'b0, nack: 1'b0, lat: 144, exp_ack: 1'b1};
    launch(v);
    repeat (70) @(posedge clk);
    #1;
    check("mid_ack_before_reset", 64'(bus.ack), 64'd1);
    reset = 1'b1;
    drop_requests();
    @(posedge clk); #1;
    exp_q.delete();
    check("abort_scl", 64'(bus.serial_clk), 64'd1);
    check("abort_sda", 64'(sda), 64'd1);
    check("abort_ack", 64'(bus.ack), 64'd0);
    check("abort_tc", 64'(bus.transfer_complete), 64'd0);
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("abort_quiet_scl", 64'(bus.serial_clk), 64'd1);
    v = '{start: 1'b0, stop: 1'b1, td: 1'b0, data: 8'h00, chg: 1'b0, nack: 1'b0, lat: 16, exp_ack: 1'b0};
    run_vec("post_reset_stop", v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
